display_scan_mux: RTL and testbench
===================================

DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 27000, giving the clock cycles per digit slot; legal values are 2 or more.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port data_i, input, 16 bits: the four hex digits to show; [3:0] is digit 0, the least significant.
REQ-005 SHALL have port load_i, input, 1 bit: a one-cycle strobe that captures data_i.
REQ-006 SHALL have port enable_i, input, 1 bit: 0 blanks the whole display.
REQ-007 SHALL have port nibble_o, output, 4 bits: the nibble for the active digit, sent to the downstream bin-to-7-segment decoder; 4'hF is the blank code.
REQ-008 SHALL have port an_o, output, 4 bits: the digit anode selects, active-low; bit k drives digit k.
REQ-009 SHALL have port digit_o, output, 2 bits: the index of the active digit.
REQ-010 SHALL have port pending_o, output, 1 bit: 1 when a loaded value is waiting to be committed.

Function
REQ-011 SHALL count a prescaler from 0 to REFRESH_DIV-1 and wrap; the cycle with count == REFRESH_DIV-1 is a tick.
REQ-012 SHALL advance the digit index by one on each tick, in the order 0,1,2,3,0.
REQ-013 SHALL have a frame boundary on any tick that occurs while the digit index is 3.
REQ-014 SHALL, on load_i=1, capture data_i into a shadow register and set pending to 1.
REQ-015 SHALL, on a frame boundary with pending=1 and load_i=0, copy the shadow register into the display register and clear pending.
REQ-016 SHALL, when load_i=1 coincides with a frame boundary, write data_i directly into both the shadow and display registers and leave pending at 0.
REQ-017 SHALL, on back-to-back loads within one frame, keep only the last value; no intermediate value is ever displayed.
REQ-018 SHALL change the displayed value only at frame boundaries, so the display never tears.
REQ-019 SHALL drive nibble_o, an_o and digit_o from registered state only, with no combinational path from any input; the outputs reflect a new digit in the cycle after the tick.
REQ-020 SHALL, with enable_i=1, drive an_o with only bit digit_o low and drive nibble_o with the corresponding display nibble.
REQ-021 SHALL, with enable_i=0, drive an_o=4'b1111 and nibble_o=4'hF; the prescaler, digit scan and load logic keep running.
REQ-022 SHALL drive pending_o as a direct copy of the pending flag.

Reset
REQ-023 SHALL, with rst=1, clear the prescaler, digit index, display register, shadow register and pending on the next clk edge.
REQ-024 SHALL make the post-reset outputs nibble_o=4'h0, an_o=4'b1110, digit_o=0 and pending_o=0.
REQ-025 SHALL give rst priority over load_i and ticks; an asserted reset mid-frame discards any pending value.

Configuration
REQ-026 SHALL compile in leading-zero blanking when the macro DISPLAY_LEADING_ZERO_BLANK_EN is defined.
REQ-027 SHALL, with the macro defined, output nibble_o=4'hF with that anode still driven for any digit k ≥ 1 whose display nibbles k through 3 are all zero; digit 0 is never blanked.
REQ-028 SHALL, without the macro, always output the raw display nibble.

Verification (REFRESH_DIV=4)
REQ-029 SHALL cover: release reset and run 32 cycles -> an_o goes 1110,1101,1011,0111 repeating, each for 4 cycles, and nibble_o stays 0.
REQ-030 SHALL cover: load 16'h12AB mid-frame -> pending_o=1 until the next frame boundary, then digits 0..3 show B,A,2,1.
REQ-031 SHALL cover: load 16'h1111 then 16'h2222 within one frame -> only 2 appears and 1 is never shown.
REQ-032 SHALL cover: load 16'h00C5 on a frame-boundary cycle -> committed immediately and pending_o is never 1.
REQ-033 SHALL cover: enable_i=0 for one frame -> an_o=4'b1111 and nibble_o=4'hF; with enable_i=1 again the scan phase is unchanged.
REQ-034 SHALL cover: with the macro defined, load 16'h0005 -> digits 1..3 give nibble_o=4'hF and digit 0 gives 5; load 16'h0000 -> digit 0 gives 0.

Source files
------------

// File: rtl/display_scan_mux.sv
// Four-digit multiplexed display scanner with tear-free double-buffered loads.
// Optional leading-zero blanking is compiled in with `define DISPLAY_LEADING_ZERO_BLANK_EN.
module display_scan_mux #(
  parameter int REFRESH_DIV = 27000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_i,
  input  logic        load_i,
  input  logic        enable_i,
  output logic [3:0]  nibble_o,
  output logic [3:0]  an_o,
  output logic [1:0]  digit_o,
  output logic        pending_o
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  generate
    if (REFRESH_DIV < 2) begin : g_bad_div
      $error("display_scan_mux: REFRESH_DIV must be at least 2");
    end
  endgenerate

  logic [CNT_W-1:0] r_presc;
  logic [1:0]       r_digit;
  logic [15:0]      r_shadow;
  logic [15:0]      r_disp;
  logic             r_pending;
  logic [3:0]       r_nibble;
  logic [3:0]       r_an;

  logic        w_tick;
  logic        w_frame;
  logic [1:0]  w_digit_nxt;
  logic [15:0] w_disp_nxt;
  logic [3:0]  w_nibble_nxt;
  logic [3:0]  w_an_nxt;

  assign w_tick      = (r_presc == CNT_LAST);
  assign w_frame     = w_tick && (r_digit == 2'd3);
  assign w_digit_nxt = w_tick ? r_digit + 2'd1 : r_digit;

  // The display register only ever changes at a frame boundary, so a scan never mixes two values.
  always_comb begin
    w_disp_nxt = r_disp;
    if (w_frame) begin
      if (load_i)         w_disp_nxt = data_i;
      else if (r_pending) w_disp_nxt = r_shadow;
    end
  end

  // Outputs are precomputed from next-state values so they can be registered and still
  // show the new digit in the cycle right after the tick.
  always_comb begin
    logic [3:0] raw;
    logic       blank_lz;
    raw      = 4'h0;
    blank_lz = 1'b0;
    case (w_digit_nxt)
      2'd0: raw = w_disp_nxt[3:0];
      2'd1: raw = w_disp_nxt[7:4];
      2'd2: raw = w_disp_nxt[11:8];
      default: raw = w_disp_nxt[15:12];
    endcase
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    case (w_digit_nxt)
      2'd1: blank_lz = (w_disp_nxt[15:4] == 12'h000);
      2'd2: blank_lz = (w_disp_nxt[15:8] == 8'h00);
      2'd3: blank_lz = (w_disp_nxt[15:12] == 4'h0);
      default: blank_lz = 1'b0;
    endcase
`endif
    if (!enable_i) begin
      w_nibble_nxt = 4'hF;
      w_an_nxt     = 4'b1111;
    end else begin
      w_nibble_nxt = blank_lz ? 4'hF : raw;
      w_an_nxt     = ~(4'b0001 << w_digit_nxt);
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let the load logic see the updated digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc   <= '0;
      r_digit   <= 2'd0;
      r_shadow  <= 16'h0000;
      r_disp    <= 16'h0000;
      r_pending <= 1'b0;
      r_nibble  <= 4'h0;
      r_an      <= 4'b1110;
    end else begin
      r_presc  <= w_tick ? '0 : r_presc + 1'b1;
      r_digit  <= w_digit_nxt;
      r_disp   <= w_disp_nxt;
      r_nibble <= w_nibble_nxt;
      r_an     <= w_an_nxt;
      if (load_i) begin
        r_shadow  <= data_i;
        r_pending <= !w_frame;
      end else if (w_frame) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign nibble_o  = r_nibble;
  assign an_o      = r_an;
  assign digit_o   = r_digit;
  assign pending_o = r_pending;

endmodule

// File: tb/tb_display_scan_mux.sv
// Self-checking bench for display_scan_mux (REFRESH_DIV=4) against a cycle-count reference model.
// Define DISPLAY_LEADING_ZERO_BLANK_EN for both files to test the blanking build.
module tb_display_scan_mux;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_i = 16'h0000;
  logic        load_i = 1'b0;
  logic        enable_i = 1'b1;
  logic [3:0]  nibble_o;
  logic [3:0]  an_o;
  logic [1:0]  digit_o;
  logic        pending_o;

  int checks   = 0;
  int failures = 0;

  // Reference model: position in the scan is just cycles since reset.
  int          m_cyc;
  logic [15:0] m_disp, m_shadow;
  logic        m_pend;
  logic [3:0]  m_nib, m_an;
  logic [1:0]  m_dig;

  display_scan_mux #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .load_i(load_i), .enable_i(enable_i),
    .nibble_o(nibble_o), .an_o(an_o), .digit_o(digit_o), .pending_o(pending_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, m_cyc, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_nibble(input logic [15:0] disp, input int dig);
    logic [15:0] upper;
    upper = disp >> (4 * dig);
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    if (dig >= 1 && upper == 16'h0000) return 4'hF;
`endif
    return upper[3:0];
  endfunction

  task automatic model_edge(input logic r, input logic ld, input logic [15:0] d, input logic en);
    bit frame;
    int dig;
    if (r) begin
      m_cyc = 0; m_disp = 0; m_shadow = 0; m_pend = 0;
      m_dig = 0; m_an = 4'b1110; m_nib = 4'h0;
      return;
    end
    frame = ((m_cyc % (4 * DIV)) == (4 * DIV - 1));
    if (ld) begin
      m_shadow = d;
      if (frame) begin m_disp = d; m_pend = 0; end
      else m_pend = 1;
    end else if (frame && m_pend) begin
      m_disp = m_shadow;
      m_pend = 0;
    end
    m_cyc++;
    dig   = (m_cyc / DIV) % 4;
    m_dig = 2'(dig);
    m_an  = en ? 4'(~(1 << dig)) : 4'b1111;
    m_nib = en ? model_nibble(m_disp, dig) : 4'hF;
  endtask

  task automatic step(input logic r, input logic ld, input logic [15:0] d, input logic en);
    rst = r; load_i = ld; data_i = d; enable_i = en;
    @(posedge clk);
    model_edge(r, ld, d, en);
    #1;
    check("digit_o", 16'(digit_o), 16'(m_dig));
    check("an_o", 16'(an_o), 16'(m_an));
    check("nibble_o", 16'(nibble_o), 16'(m_nib));
    check("pending_o", 16'(pending_o), 16'(m_pend));
  endtask

  task automatic idle(input int n, input logic en);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, en);
  endtask

  // Advance to a given cycle position within the 16-cycle frame (bounded to one frame).
  task automatic run_to(input int phase);
    for (int i = 0; i < 4 * DIV && (m_cyc % (4 * DIV)) != phase; i++) step(1'b0, 1'b0, 16'h0000, 1'b1);
  endtask

  initial begin
    m_cyc = 0; m_disp = 0; m_shadow = 0; m_pend = 0;
    m_dig = 0; m_an = 4'b1110; m_nib = 0;

    // Reset state
    step(1'b1, 1'b0, 16'h0000, 1'b1);
    step(1'b1, 1'b1, 16'hFFFF, 1'b0);
    check("reset_an", 16'(an_o), 16'h000E);
    check("reset_nibble", 16'(nibble_o), 16'h0000);

    // Free-running scan of zeros
    idle(32, 1'b1);

    // Mid-frame load, committed at the next boundary
    run_to(5);
    step(1'b0, 1'b1, 16'h12AB, 1'b1);
    check("pending_after_load", 16'(pending_o), 16'h0001);
    idle(20, 1'b1);
    check("disp_12AB_committed", m_disp, 16'h12AB);

    // Back-to-back loads: only the last one is shown
    run_to(2);
    step(1'b0, 1'b1, 16'h1111, 1'b1);
    run_to(6);
    step(1'b0, 1'b1, 16'h2222, 1'b1);
    idle(20, 1'b1);

    // Load exactly on a frame boundary: immediate commit, never pending
    run_to(15);
    step(1'b0, 1'b1, 16'h00C5, 1'b1);
    check("boundary_no_pending", 16'(pending_o), 16'h0000);
    idle(16, 1'b1);

    // Blank for one frame, then resume on the same scan phase
    idle(16, 1'b0);
    idle(16, 1'b1);

    // Reset mid-frame discards a pending value
    run_to(4);
    step(1'b0, 1'b1, 16'hBEEF, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b1);
    idle(20, 1'b1);

    // Leading-zero patterns
    run_to(3);
    step(1'b0, 1'b1, 16'h0005, 1'b1);
    idle(20, 1'b1);
    step(1'b0, 1'b1, 16'h0000, 1'b1);
    idle(20, 1'b1);
    step(1'b0, 1'b1, 16'h0300, 1'b1);
    idle(20, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic r, ld, en;
      r  = ($urandom_range(0, 99) == 0);
      ld = ($urandom_range(0, 7) == 0);
      en = ($urandom_range(0, 9) != 0);
      step(r, ld, 16'($urandom), en);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
